// File: rtl/fetch_stage_if.sv
// Narrow memory read bus between the fetch stage (master) and instruction memory (slave).
// mem_req/mem_addr are driven by the master; mem_ready/mem_rdata/mem_err by the slave.
interface fetch_stage_if #(
    parameter int BUS_WIDTH = 8
);
    // Handshake: a beat completes on any rising edge where mem_req & mem_ready are both 1.
    // mem_addr is held while mem_req=1 and mem_ready=0. mem_rdata and mem_err are only
    // meaningful in that completing cycle. A request, once raised, is held until it completes.
    logic                 mem_req;
    logic [31:0]          mem_addr;
    logic                 mem_ready;
    logic [BUS_WIDTH-1:0] mem_rdata;
    logic                 mem_err;

    modport master (
        output mem_req,
        output mem_addr,
        input  mem_ready,
        input  mem_rdata,
        input  mem_err
    );

    modport slave (
        input  mem_req,
        input  mem_addr,
        output mem_ready,
        output mem_rdata,
        output mem_err
    );
endinterface

// File: rtl/fetch_stage.sv
// Instruction fetch stage: reads one 32-bit little-endian word at pc in BUS_WIDTH-bit beats
// and reports done / misalignment / bus-error status to the core FSM.
module fetch_stage #(
    parameter int BUS_WIDTH     = 8,
    parameter int PC_ALIGN_BITS = 2
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          active,
    input  logic [31:0]   pc,
    output logic          done,
    output logic [31:0]   instr,
    output logic          mem_addr_fault,
    output logic          mem_access_fault,
    output logic [1:0]    dbg_state,
    fetch_stage_if.master mem
);

    localparam int          BEATS     = 32 / BUS_WIDTH;
    localparam logic [1:0]  LAST_BEAT = 2'(BEATS - 1);
    localparam logic [31:0] ADDR_STEP = 32'(BUS_WIDTH / 8);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_REQ   = 2'd1,
        S_DONE  = 2'd2,
        S_DRAIN = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [1:0]  beat_q, beat_d;
    logic        mem_req_q, mem_req_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [31:0] instr_q, instr_d;
    logic        done_q, done_d;
    logic        addr_fault_q, addr_fault_d;
    logic        access_fault_q, access_fault_d;
    logic        beat_hit;

    assign beat_hit = mem_req_q & mem.mem_ready;

    always_comb begin
        state_d        = state_q;
        beat_d         = beat_q;
        mem_req_d      = mem_req_q;
        mem_addr_d     = mem_addr_q;
        instr_d        = instr_q;
        done_d         = done_q;
        addr_fault_d   = addr_fault_q;
        access_fault_d = access_fault_q;

        case (state_q)
            S_IDLE: begin
                if (active) begin
                    if (|pc[PC_ALIGN_BITS-1:0]) begin
                        state_d      = S_DONE;
                        done_d       = 1'b1;
                        addr_fault_d = 1'b1;
                    end else begin
                        state_d        = S_REQ;
                        mem_req_d      = 1'b1;
                        mem_addr_d     = pc;
                        beat_d         = 2'd0;
                        instr_d        = 32'd0;
                        addr_fault_d   = 1'b0;
                        access_fault_d = 1'b0;
                    end
                end
            end

            S_REQ: begin
                if (beat_hit) begin
                    if (mem.mem_err) begin
                        // An error seen after active dropped is swallowed: nobody is waiting for status.
                        mem_req_d      = 1'b0;
                        state_d        = active ? S_DONE : S_IDLE;
                        done_d         = active;
                        access_fault_d = active;
                    end else begin
                        instr_d[int'(beat_q)*BUS_WIDTH +: BUS_WIDTH] = mem.mem_rdata;
                        // Advancing on the last beat too leaves mem_addr one past the word (wrapping).
                        mem_addr_d = mem_addr_q + ADDR_STEP;
                        if (beat_q == LAST_BEAT) begin
                            mem_req_d = 1'b0;
                            state_d   = active ? S_DONE : S_IDLE;
                            done_d    = active;
                        end else begin
                            beat_d = beat_q + 2'd1;
                            if (!active) begin
                                state_d = S_DRAIN;
                            end
                        end
                    end
                end else if (!active) begin
                    state_d = S_DRAIN;
                end
            end

            S_DRAIN: begin
                if (beat_hit) begin
                    mem_req_d = 1'b0;
                    state_d   = S_IDLE;
                end
            end

            S_DONE: begin
                if (!active) begin
                    state_d        = S_IDLE;
                    done_d         = 1'b0;
                    addr_fault_d   = 1'b0;
                    access_fault_d = 1'b0;
                end
            end

            default: begin
                state_d   = S_IDLE;
                mem_req_d = 1'b0;
                done_d    = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= S_IDLE;
            beat_q         <= 2'd0;
            mem_req_q      <= 1'b0;
            mem_addr_q     <= 32'd0;
            instr_q        <= 32'd0;
            done_q         <= 1'b0;
            addr_fault_q   <= 1'b0;
            access_fault_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            beat_q         <= beat_d;
            mem_req_q      <= mem_req_d;
            mem_addr_q     <= mem_addr_d;
            instr_q        <= instr_d;
            done_q         <= done_d;
            addr_fault_q   <= addr_fault_d;
            access_fault_q <= access_fault_d;
        end
    end

    assign done             = done_q;
    assign instr            = instr_q;
    assign mem_addr_fault   = addr_fault_q;
    assign mem_access_fault = access_fault_q;
    assign dbg_state        = state_q;
    assign mem.mem_req      = mem_req_q;
    assign mem.mem_addr     = mem_addr_q;

endmodule
